// File: rtl/sound_sequencer_if.sv
// Request/tone bundle between game logic (master) and the sound sequencer (slave).
interface sound_sequencer_if;
    logic [3:0] req;
    logic [3:0] tone;
    logic       tone_en;
    logic       busy;
    logic [1:0] active_id;
    logic       done;

    modport master (output req, input tone, tone_en, busy, active_id, done);
    modport slave  (input req, output tone, tone_en, busy, active_id, done);
endinterface

// File: rtl/sound_sequencer.sv
// Shares one tone generator between four sound effects: fixed-priority arbitration
// with preemption, each effect stepped out of a note ROM with per-note durations.
module sound_sequencer #(
    parameter int unsigned TICK_DIV = 315000
) (
    input  logic             clk,
    input  logic             resetN,
    sound_sequencer_if.slave snd
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

    typedef struct packed {
        logic [3:0] tone;
        logic [5:0] dur;
        logic       last;
    } step_t;

    localparam int            TW        = 20;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [3:0]    pending_q;
    logic [1:0]    active_id_q;
    logic [2:0]    step_q;
    logic [TW-1:0] tick_q;
    logic [5:0]    dur_cnt_q;
    logic          last_q;
    logic [3:0]    tone_q;
    logic          tone_en_q;

    step_t         rom;
    logic [1:0]    pick_id;
    logic          any_pending;
    logic          preempt;
    logic          launch;
    logic          tick_wrap;
    logic          note_end;
    logic [3:0]    launch_mask;

    always_comb begin : step_rom
        // NOTE: a default before the case keeps this purely combinational (no latch).
        rom = '{tone: 4'd0, dur: 6'd1, last: 1'b1};
        case ({active_id_q, step_q})
            5'b00_000: rom = '{tone: 4'd12, dur: 6'd2,  last: 1'b0};
            5'b00_001: rom = '{tone: 4'd9,  dur: 6'd2,  last: 1'b0};
            5'b00_010: rom = '{tone: 4'd4,  dur: 6'd2,  last: 1'b1};
            5'b01_000: rom = '{tone: 4'd0,  dur: 6'd4,  last: 1'b0};
            5'b01_001: rom = '{tone: 4'd2,  dur: 6'd4,  last: 1'b1};
            5'b10_000: rom = '{tone: 4'd9,  dur: 6'd6,  last: 1'b0};
            5'b10_001: rom = '{tone: 4'd7,  dur: 6'd6,  last: 1'b0};
            5'b10_010: rom = '{tone: 4'd5,  dur: 6'd6,  last: 1'b0};
            5'b10_011: rom = '{tone: 4'd4,  dur: 6'd6,  last: 1'b0};
            5'b10_100: rom = '{tone: 4'd2,  dur: 6'd6,  last: 1'b0};
            5'b10_101: rom = '{tone: 4'd0,  dur: 6'd12, last: 1'b1};
            5'b11_000: rom = '{tone: 4'd12, dur: 6'd3,  last: 1'b0};
            5'b11_001: rom = '{tone: 4'd15, dur: 6'd3,  last: 1'b0};
            5'b11_010: rom = '{tone: 4'd12, dur: 6'd3,  last: 1'b0};
            5'b11_011: rom = '{tone: 4'd15, dur: 6'd3,  last: 1'b1};
            default:   ;
        endcase
    end

    // Highest pending id wins; only a strictly higher id may interrupt a sound.
    always_comb begin : arbiter
        pick_id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pending_q[i]) pick_id = 2'(i);
        end
    end

    assign any_pending = |pending_q;
    assign preempt     = (state_q == S_LOAD || state_q == S_PLAY) && (pick_id > active_id_q);
    assign launch      = (state_q == S_IDLE && any_pending) || preempt;
    assign launch_mask = launch ? (4'b0001 << pick_id) : 4'b0000;
    assign tick_wrap   = (tick_q == TICK_LAST);
    assign note_end    = (state_q == S_PLAY) && tick_wrap && (dur_cnt_q == 6'd1);

    always_ff @(posedge clk or negedge resetN) begin : state_reg
        if (!resetN) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: if (any_pending) state_d = S_LOAD;
            S_LOAD: state_d = preempt ? S_LOAD : S_PLAY;
            S_PLAY: begin
                if (preempt)       state_d = S_LOAD;
                else if (note_end) state_d = last_q ? S_DONE : S_LOAD;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin : datapath
        if (!resetN) begin
            pending_q   <= 4'b0000;
            active_id_q <= 2'd0;
            step_q      <= 3'd0;
            tick_q      <= '0;
            dur_cnt_q   <= 6'd0;
            last_q      <= 1'b0;
            tone_q      <= 4'd0;
            tone_en_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values together.
            pending_q <= (pending_q & ~launch_mask) | snd.req;

            if (launch) begin
                active_id_q <= pick_id;
                step_q      <= 3'd0;
            end else if (note_end && !last_q) begin
                step_q <= step_q + 3'd1;
            end

            if (state_q == S_LOAD && !preempt) begin
                tone_q    <= rom.tone;
                tone_en_q <= 1'b1;
                dur_cnt_q <= (rom.dur == 6'd0) ? 6'd1 : rom.dur;
                tick_q    <= '0;
                last_q    <= rom.last;
            end else if (state_q == S_PLAY && !preempt) begin
                tick_q <= tick_wrap ? '0 : tick_q + TW'(1);
                if (tick_wrap)          dur_cnt_q <= dur_cnt_q - 6'd1;
                if (note_end && last_q) tone_en_q <= 1'b0;
            end
        end
    end

    always_comb begin : outputs
        snd.tone      = tone_q;
        snd.tone_en   = tone_en_q;
        snd.active_id = active_id_q;
        snd.busy      = (state_q != S_IDLE);
        snd.done      = (state_q == S_DONE);
    end
endmodule
